// File: rtl/fft_pkg.sv
// Shared FFT types and constants: default widths, packed complex sample and
// twiddle types, and the two trivial twiddles W0 (1.0) and W1 (-j).
package fft_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int TW_W_DEF   = 16;
    localparam int TAG_W_DEF  = 10;

    typedef struct packed {
        logic signed [DATA_W_DEF-1:0] re;
        logic signed [DATA_W_DEF-1:0] im;
    } cplx_t;

    typedef struct packed {
        logic signed [TW_W_DEF-1:0] re;
        logic signed [TW_W_DEF-1:0] im;
    } twid_t;

    // W0 = +max (closest to 1.0), W1 = -1.0 on the imaginary axis (-j).
    localparam twid_t W0 = twid_t'({1'b0, {(TW_W_DEF-1){1'b1}}, {TW_W_DEF{1'b0}}});
    localparam twid_t W1 = twid_t'({{TW_W_DEF{1'b0}}, 1'b1, {(TW_W_DEF-1){1'b0}}});

endpackage

// File: rtl/fft_bfly_pipe_if.sv
// Stream bundle for the pipelined butterfly: input beat, result beat and the
// sticky-overflow control. slave = butterfly side, master = surrounding logic.
interface fft_bfly_pipe_if
    import fft_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int TW_W   = TW_W_DEF,
    parameter int TAG_W  = TAG_W_DEF
);
    logic                  in_valid;
    logic                  in_ready;
    logic [2*DATA_W-1:0]   in_a;
    logic [2*DATA_W-1:0]   in_b;
    logic [2*TW_W-1:0]     in_w;
    logic                  in_scale;
    logic [TAG_W-1:0]      in_tag;
    logic                  out_valid;
    logic                  out_ready;
    logic [2*DATA_W-1:0]   out_sum;
    logic [2*DATA_W-1:0]   out_diff;
    logic [TAG_W-1:0]      out_tag;
    logic                  ovf_clr;
    logic                  ovf_sticky;

    modport master (
        output in_valid, in_a, in_b, in_w, in_scale, in_tag, out_ready, ovf_clr,
        input  in_ready, out_valid, out_sum, out_diff, out_tag, ovf_sticky
    );

    modport slave (
        input  in_valid, in_a, in_b, in_w, in_scale, in_tag, out_ready, ovf_clr,
        output in_ready, out_valid, out_sum, out_diff, out_tag, ovf_sticky
    );
endinterface

// File: rtl/fft_cmul_round.sv
// Complex multiply B*W with one register stage on the full-precision products,
// followed by round-half-up back to Q1.(DATA_W-1) at DATA_W+1 bits.
module fft_cmul_round
    import fft_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int TW_W   = TW_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic signed [DATA_W-1:0] b_re,
    input  logic signed [DATA_W-1:0] b_im,
    input  logic signed [TW_W-1:0]   w_re,
    input  logic signed [TW_W-1:0]   w_im,
    output logic signed [DATA_W:0]   bw_re,
    output logic signed [DATA_W:0]   bw_im
);
    // One extra bit over a single product so the re/im combine never wraps.
    localparam int PW = DATA_W + TW_W + 1;
    localparam logic signed [PW-1:0] HALF = PW'(1) << (TW_W - 2);

    logic signed [PW-1:0] mult_re;
    logic signed [PW-1:0] mult_im;

    // NOTE: registers use non-blocking assignments so every flop samples the
    // pre-edge value of its inputs regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mult_re <= '0;
            mult_im <= '0;
        end else if (en) begin
            mult_re <= PW'(b_re) * PW'(w_re) - PW'(b_im) * PW'(w_im);
            mult_im <= PW'(b_re) * PW'(w_im) + PW'(b_im) * PW'(w_re);
        end
    end

    // DATA_W+1 bits keep (-1)*(-1) = +1.0 exact.
    assign bw_re = (DATA_W+1)'((mult_re + HALF) >>> (TW_W - 1));
    assign bw_im = (DATA_W+1)'((mult_im + HALF) >>> (TW_W - 1));

endmodule

// File: rtl/fft_bfly_pipe.sv
// 3-stage radix-2 DIT butterfly (sum = A + B*W, diff = A - B*W) with global
// stall flow control. Define FFT_BFLY_SAT_EN to clamp overflows instead of wrapping.
module fft_bfly_pipe
    import fft_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int TW_W   = TW_W_DEF,
    parameter int TAG_W  = TAG_W_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    fft_bfly_pipe_if.slave  bus
);
    localparam int SW = DATA_W + 2;

    logic advance;
    assign advance      = bus.out_ready | ~bus.out_valid;
    assign bus.in_ready = advance;

    // S1: registered inputs
    logic                v1, scale1;
    logic [2*DATA_W-1:0] a1, b1;
    logic [2*TW_W-1:0]   w1;
    logic [TAG_W-1:0]    tag1;
    // S2: A and sideband alongside the registered products
    logic                v2, scale2;
    logic [2*DATA_W-1:0] a2;
    logic [TAG_W-1:0]    tag2;

    // NOTE: datapath stages are reset along with the valids so the output
    // registers read 0 after reset and no X ever reaches the products.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1 <= 1'b0; scale1 <= 1'b0; a1 <= '0; b1 <= '0; w1 <= '0; tag1 <= '0;
            v2 <= 1'b0; scale2 <= 1'b0; a2 <= '0; tag2 <= '0;
        end else if (advance) begin
            v1 <= bus.in_valid; scale1 <= bus.in_scale; tag1 <= bus.in_tag;
            a1 <= bus.in_a;     b1 <= bus.in_b;         w1 <= bus.in_w;
            v2 <= v1; scale2 <= scale1; a2 <= a1; tag2 <= tag1;
        end
    end

    logic signed [DATA_W:0] bw_re, bw_im;

    fft_cmul_round #(.DATA_W(DATA_W), .TW_W(TW_W)) u_cmul (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (advance),
        .b_re  (b1[2*DATA_W-1:DATA_W]),
        .b_im  (b1[DATA_W-1:0]),
        .w_re  (w1[2*TW_W-1:TW_W]),
        .w_im  (w1[TW_W-1:0]),
        .bw_re (bw_re),
        .bw_im (bw_im)
    );

    // Returns {overflow, value reduced to DATA_W}.
    function automatic logic [DATA_W:0] reduce(input logic signed [SW-1:0] v);
        logic fits;
        fits = (&v[SW-1:DATA_W-1]) | ~(|v[SW-1:DATA_W-1]);
`ifdef FFT_BFLY_SAT_EN
        if (!fits) return {1'b1, v[SW-1], {(DATA_W-1){~v[SW-1]}}};
`endif
        return {~fits, v[DATA_W-1:0]};
    endfunction

    logic signed [DATA_W-1:0] a2_re, a2_im;
    logic signed [SW-1:0]     s_re, s_im, d_re, d_im;
    logic [DATA_W:0]          r_sr, r_si, r_dr, r_di;
    logic                     ovf_any;

    assign a2_re = a2[2*DATA_W-1:DATA_W];
    assign a2_im = a2[DATA_W-1:0];

    // NOTE: every always_comb output is assigned on all paths (the scale
    // shift overwrites an already-assigned value), so no latch is inferred.
    always_comb begin
        s_re = SW'(a2_re) + SW'(bw_re);
        s_im = SW'(a2_im) + SW'(bw_im);
        d_re = SW'(a2_re) - SW'(bw_re);
        d_im = SW'(a2_im) - SW'(bw_im);
        if (scale2) begin
            s_re = s_re >>> 1;
            s_im = s_im >>> 1;
            d_re = d_re >>> 1;
            d_im = d_im >>> 1;
        end
        r_sr    = reduce(s_re);
        r_si    = reduce(s_im);
        r_dr    = reduce(d_re);
        r_di    = reduce(d_im);
        ovf_any = r_sr[DATA_W] | r_si[DATA_W] | r_dr[DATA_W] | r_di[DATA_W];
    end

    // S3: output registers and sticky overflow (a new overflow beats a clear).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid  <= 1'b0;
            bus.out_sum    <= '0;
            bus.out_diff   <= '0;
            bus.out_tag    <= '0;
            bus.ovf_sticky <= 1'b0;
        end else begin
            if (advance) begin
                bus.out_valid <= v2;
                if (v2) begin
                    bus.out_sum  <= {r_sr[DATA_W-1:0], r_si[DATA_W-1:0]};
                    bus.out_diff <= {r_dr[DATA_W-1:0], r_di[DATA_W-1:0]};
                    bus.out_tag  <= tag2;
                end
            end
            if (advance && v2 && ovf_any) bus.ovf_sticky <= 1'b1;
            else if (bus.ovf_clr)         bus.ovf_sticky <= 1'b0;
        end
    end

endmodule

// File: doc/fft_bfly_pipe.md
Name: fft_bfly_pipe

Overview:
- Pipelined, parametrised radix-2 DIT butterfly for the FFT core: sum = A + B·W, diff = A − B·W.
- Successor to the combinational butterfly. Adds configurable data/twiddle widths, a 3-stage registered pipeline with valid/ready flow control, and round-half-up twiddle scaling.
- Also adds an optional per-transaction divide-by-2 (block scaling) and a sticky overflow flag.
- Sits between the stage sample RAM read port and write-back; one butterfly per cycle at full throughput.

Parameters:
- DATA_W, 16, bits per real/imag component of A, B, sum, diff (signed Q1.(DATA_W-1)).
- TW_W, 16, bits per twiddle component (signed Q1.(TW_W-1)).
- TAG_W, 10, width of the sideband tag carried alongside data (butterfly index/address).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- in_a  in  2*DATA_W  packed {re,im}.
- in_b  in  2*DATA_W  packed {re,im}.
- in_w  in  2*TW_W  twiddle, packed {re,im}.
- in_scale  in  1  1 = halve both results of this beat.
- in_tag  in  TAG_W  sideband, returned unchanged.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_sum  out  2*DATA_W  packed {re,im}.
- out_diff  out  2*DATA_W  packed {re,im}.
- out_tag  out  TAG_W  tag of this result.
- ovf_clr  in  1  synchronous clear of ovf_sticky.
- ovf_sticky  out  1  set on any component overflow since last clear/reset.

Behaviour:
- Reset (rst_n low, async): all stage valids = 0, out_valid = 0, out_sum/out_diff/out_tag = 0, ovf_sticky = 0. in_ready = 1 once released. Reset mid-stream discards all in-flight beats; nothing is emitted afterwards for them.
- Pipeline: S1 registers inputs; S2 forms the 4 products and the re/im combines; S3 rounds, adds/subs, scales, saturates and registers outputs. Latency 3 cycles from accepted beat to out_valid, with no stall.
- Flow control: advance = out_ready | ~out_valid. in_ready = advance. When advance = 0, all stages hold (global stall). A beat transfers when valid & ready are both high. Throughput is 1/cycle when out_ready is held high. Order is preserved; no beat is dropped or duplicated.
- Products: mult_re = B_re·W_re − B_im·W_im and mult_im = B_re·W_im + B_im·W_re, held at DATA_W+TW_W+1 bits with no wrap.
- Rounding: BW = (mult + 2^(TW_W-2)) >>> (TW_W-1), kept at DATA_W+1 bits. This width is required so that (−1)·(−1) = +1.0 is representable.
- Add/sub: A ± BW at DATA_W+2 bits. If the beat's scale = 1, arithmetic shift right by 1 (floor).
- Range: the result is reduced to DATA_W bits; a value outside [−2^(DATA_W-1), 2^(DATA_W-1)−1] is an overflow. Overflow on any of the 4 components sets ovf_sticky in the cycle the beat is registered in S3.
- ovf_sticky: ovf_clr clears it. If ovf_clr and a new overflow occur in the same cycle, set wins.
- Twiddle 0x8000 in re or im is legal and fully supported.

Optional Feature:
- FFT_BFLY_SAT_EN defined: overflowing components clamp to the max/min of DATA_W.
- Undefined: overflowing components wrap (two's-complement truncation).
- ovf_sticky reporting is identical in both builds.

Decomposition:
- fft_pkg gains:
  - DATA_W/TW_W defaults;
  - W0 = {0x7FFF,0x0000} and W1 = {0x0000,0x8000} scaled to TW_W;
  - typedef cplx_t (packed signed re/im of DATA_W);
  - typedef twid_t (packed signed re/im of TW_W).
- One natural sub-module: fft_cmul_round (S2 products plus rounding, TW_W/DATA_W parametrised). Reusable by the radix-4 block.

Test Plan:
- A={1000,−2000}, B={4000,3000}, W=W0, scale=0 -> after 3 cycles sum={5000,1000}, diff={−3000,−5000}, ovf_sticky=0, tag echoed.
- Same A,B, W=W1={0,−32768} -> BW={3000,−4000}; sum={4000,−6000}, diff={−2000,2000}.
- A=0, B={−32768,0}, W={−32768,0} -> BW_re=+32768. SAT build: sum_re=32767, diff_re=−32768, ovf_sticky=1. Wrap build: sum_re=−32768, ovf_sticky=1. ovf_clr then clears it.
- A={30000,30000}, B={30000,−30000}, W=W0, scale=1 -> sum={29999,0}, diff={0,29999}, no overflow.
- Back-to-back 8 beats with tags 0..7; out_ready low for 5 cycles mid-stream -> in_ready low while stalled, outputs held stable, all 8 results emitted in tag order with none lost.
- rst_n asserted with 3 beats in flight -> out_valid=0 and outputs 0 immediately; no stale results after release; the next beat has latency 3.
